pipe_reg_chain: RTL and testbench
=================================

// Module: pipe_reg_chain
// PURPOSE
//  Parametrised elastic pipeline register: DEPTH stages of WIDTH-bit data with valid/ready
//  handshake, per-stage bubble collapsing, synchronous flush. Successor to the plain reset
//  flip-flop for datapath stage boundaries (fetch/decode/execute) needing stall and flush.
// PARAMETERS
//  WIDTH      32  data width per stage, >=1
//  DEPTH      2   number of register stages, >=1 (elaboration error if 0)
//  RESET_VAL  '0  WIDTH-bit value loaded into every data register on reset
// PORTS
//  clk        in   1              rising-edge clock
//  reset      in   1              synchronous, active-high reset
//  flush      in   1              synchronous kill of all in-flight entries
//  in_valid   in   1              upstream presents in_data
//  in_ready   out  1              chain accepts in_data this cycle
//  in_data    in   WIDTH          input payload
//  out_valid  out  1              last stage holds valid data
//  out_ready  in   1              downstream accepts out_data this cycle
//  out_data   out  WIDTH          last-stage payload
//  occupancy  out  $clog2(DEPTH+1) valid-entry count (only with PIPE_OCCUPANCY_EN)
// BEHAVIOUR
//  - State per stage k (0..DEPTH-1): v[k], d[k]. Stage 0 is input side; stage DEPTH-1 drives out_*.
//  - Ready chain (combinational): rdy[DEPTH-1] = !v[DEPTH-1] | out_ready;
//    rdy[k] = !v[k] | rdy[k+1]; in_ready = rdy[0] & !flush.
//  - Stage k loads when rdy[k] is high: v[k] <= v_prev; d[k] <= d_prev only if v_prev=1
//    (v_prev/d_prev = in_valid&!flush/in_data for k=0, else v[k-1]/d[k-1]).
//    Data regs never load on invalid input; when not loading, d and v hold.
//  - Bubbles collapse: empty stage accepts from predecessor even if out_ready=0.
//  - Latency: in_valid&in_ready at edge N -> out_valid at edge N+DEPTH-1 (visible after N+DEPTH-1),
//    i.e. DEPTH cycles with no backpressure. Throughput 1/cycle when out_ready=1.
//  - Transfer rules: in accepted iff in_valid&in_ready at rising edge; out consumed iff
//    out_valid&out_ready. out_data stable while out_valid&!out_ready.
//  - Full (all v=1, out_ready=0): in_ready=0, all state held. Full with out_ready=1:
//    simultaneous in and out accepted, occupancy unchanged.
//  - Empty: out_valid=0, out_data holds last loaded value (don't-care).
//  - flush=1: at the edge all v[k] <= 0, d held, input not accepted (in_ready=0);
//    out_valid still reflects pre-flush state that cycle; downstream may consume it.
//  - reset=1 (overrides flush and all inputs, including mid-transfer): all v <= 0,
//    all d <= RESET_VAL. After reset: in_ready=1, out_valid=0, out_data=RESET_VAL.
//  - No combinational path in_valid->out_valid or in_data->out_data; out_ready->in_ready path is allowed.
// CONFIGURATION
//  PIPE_OCCUPANCY_EN defined: occupancy port present = popcount(v), registered (updated each edge
//    from next-state v), 0 after reset and after flush; max DEPTH.
//  Not defined: occupancy port and counter logic absent; all other behaviour identical.
// STRUCTURE
//  - Package pipe_pkg: function occ_w(depth) = $clog2(depth+1); localparam MIN_DEPTH=1.
//  - Sub-module pipe_stage (one v/d pair, ports clk, reset, flush, load, v_in, d_in, v, d),
//    instantiated DEPTH times in a generate loop; ready chain in pipe_reg_chain.
// TESTING (WIDTH=8, DEPTH=3 unless noted)
//  1 reset=1 2 cycles, in_data=8'hAA, in_valid=1 -> out_valid=0, out_data=8'h00, in_ready=1.
//  2 out_ready=1, send 8'h11,8'h22,8'h33 back-to-back -> out 8'h11 valid 3 cycles after first
//    accept, then 8'h22, 8'h33 consecutive cycles; no gaps.
//  3 out_ready=0, send 8'h01..8'h04 -> 3 accepted, in_ready=0 on 4th, out_data=8'h01 stable;
//    raise out_ready -> 8'h01,02,03,04 in order, none lost/duplicated.
//  4 fill with 8'h5A,8'h5B, pulse flush 1 cycle with in_valid=1 -> next cycle all v=0,
//    out_valid=0, input during flush dropped; occupancy=0 (with PIPE_OCCUPANCY_EN).
//  5 bubble: send 8'hC0, idle 1 cycle, send 8'hC1 with out_ready=0 -> both compact into
//    stages 2,1; occupancy=2; in_ready stays 1.
//  6 assert reset while full and out_ready=1 -> next cycle out_valid=0, out_data=RESET_VAL;
//    DEPTH=1 rerun of scenario 3 -> same order, latency 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline register chain.
package pipe_pkg;

    localparam int MIN_DEPTH = 1;

    // Width of a counter able to hold 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/data register pair of the elastic chain; data only captures valid payloads.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             load,
    input  logic             v_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    // Stage register: reset beats flush, flush kills validity but keeps data.
    always_ff @(posedge clk) begin
        if (reset) begin
            v <= 1'b0;
            d <= RESET_VAL;
        end else if (flush) begin
            v <= 1'b0;
        end else if (load) begin
            v <= v_in;
            if (v_in) begin
                d <= d_in;
            end
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic DEPTH-stage valid/ready pipeline with bubble collapsing and synchronous flush.
// Define PIPE_OCCUPANCY_EN to add the registered occupancy output.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data
`ifdef PIPE_OCCUPANCY_EN
    ,
    output logic [occ_w(DEPTH)-1:0]   occupancy
`endif
);

    if (DEPTH < MIN_DEPTH) begin : g_bad_depth
        $error("pipe_reg_chain: DEPTH must be at least 1");
    end

    // Index k of the chains is the input of stage k; index k+1 is its output.
    logic [DEPTH:0]   vch_s;
    logic [WIDTH-1:0] dch_s [DEPTH+1];
    logic [DEPTH-1:0] rdy_s;
    logic             full_acc_s;

    assign vch_s[0] = in_valid & ~flush;
    assign dch_s[0] = in_data;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .load  (rdy_s[k]),
            .v_in  (vch_s[k]),
            .d_in  (dch_s[k]),
            .v     (vch_s[k+1]),
            .d     (dch_s[k+1])
        );
    end

    // Stage k may load unless it and every stage downstream are full while the sink stalls.
    always_comb begin
        rdy_s      = {DEPTH{1'b0}};
        full_acc_s = 1'b1;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            full_acc_s = full_acc_s & vch_s[k+1];
            rdy_s[k]   = ~full_acc_s | out_ready;
        end
    end

    assign in_ready  = rdy_s[0] & ~flush;
    assign out_valid = vch_s[DEPTH];
    assign out_data  = dch_s[DEPTH];

`ifdef PIPE_OCCUPANCY_EN
    localparam int OCC_W = occ_w(DEPTH);

    logic [OCC_W-1:0] occ_nxt_s;
    logic [OCC_W-1:0] occ_r;

    // Count the valid bits each stage will hold after this edge (flush/reset handled below).
    always_comb begin
        occ_nxt_s = {OCC_W{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            if (rdy_s[k]) begin
                occ_nxt_s = occ_nxt_s + OCC_W'(vch_s[k]);
            end else begin
                occ_nxt_s = occ_nxt_s + OCC_W'(vch_s[k+1]);
            end
        end
    end

    // Occupancy register tracks the next-state valid count.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_r <= {OCC_W{1'b0}};
        end else if (flush) begin
            occ_r <= {OCC_W{1'b0}};
        end else begin
            occ_r <= occ_nxt_s;
        end
    end

    assign occupancy = occ_r;
`else
    // Without the occupancy option the chain carries no counter logic.
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench: DEPTH=3 and DEPTH=1 chains driven in parallel, each against a queue model.
module tb_pipe_reg_chain;
    import pipe_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    int n_cmp    = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    task automatic chk(input string name, input int lane_id, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s lane%0d t=%0t: got %0h expected %0h", name, lane_id, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int D = (g == 0) ? 3 : 1;

        logic       in_ready_s;
        logic       out_valid_s;
        logic [7:0] out_data_s;
`ifdef PIPE_OCCUPANCY_EN
        logic [occ_w(D)-1:0] occ_s;
`endif

        pipe_reg_chain #(
            .WIDTH     (8),
            .DEPTH     (D),
            .RESET_VAL (8'h00)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_ready  (in_ready_s),
            .in_data   (in_data),
            .out_valid (out_valid_s),
            .out_ready (out_ready),
            .out_data  (out_data_s)
`ifdef PIPE_OCCUPANCY_EN
            ,
            .occupancy (occ_s)
`endif
        );

        // Reference: FIFO of accepted items with the edge at which each was captured.
        logic [7:0] q_data [$];
        int         q_acc  [$];
        bit         started = 1'b0;
        bit         rst_chk = 1'b0;
        bit         exp_ir;
        bit         exp_ov;

        always @(negedge clk) begin
            exp_ir = 1'b0;
            exp_ov = 1'b0;
            if (started) begin
                exp_ir = ((q_data.size() < D) || out_ready) && !flush;
                exp_ov = (q_data.size() > 0) && (edge_cnt >= q_acc[0] + D - 1);
                chk("in_ready", g, 32'(in_ready_s), 32'(exp_ir));
                chk("out_valid", g, 32'(out_valid_s), 32'(exp_ov));
                if (exp_ov) begin
                    chk("out_data", g, 32'(out_data_s), 32'(q_data[0]));
                end else if (rst_chk) begin
                    chk("out_data_rst", g, 32'(out_data_s), 32'h0000_0000);
                end
`ifdef PIPE_OCCUPANCY_EN
                chk("occupancy", g, 32'(occ_s), 32'(q_data.size()));
`endif
            end
            if (exp_ov) rst_chk = 1'b0;

            if (reset) begin
                q_data.delete();
                q_acc.delete();
                rst_chk = 1'b1;
                started = 1'b1;
            end else if (started) begin
                if (exp_ov && out_ready) begin
                    void'(q_data.pop_front());
                    void'(q_acc.pop_front());
                end
                if (flush) begin
                    q_data.delete();
                    q_acc.delete();
                end else if (in_valid && exp_ir) begin
                    q_data.push_back(in_data);
                    q_acc.push_back(edge_cnt + 1);
                end
            end
        end
    end

    task automatic step(input logic rst, input logic fl, input logic iv, input logic [7:0] d, input logic ordy);
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] v8;

        // Reset with a live input presented.
        step(1'b1, 1'b0, 1'b1, 8'hAA, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'hAA, 1'b0);

        // Back-to-back stream, no backpressure.
        step(1'b0, 1'b0, 1'b1, 8'h11, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h22, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h33, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Fill under backpressure, hold, then release.
        step(1'b0, 1'b0, 1'b1, 8'h01, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h02, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h03, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h04, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h04, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h04, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Partial fill then flush with a live input.
        step(1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h5B, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h77, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Bubble compaction under backpressure.
        step(1'b0, 1'b0, 1'b1, 8'hC0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'hC1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Reset while full and draining.
        step(1'b0, 1'b0, 1'b1, 8'hE1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'hE2, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'hE3, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'hE4, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // Randomised traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            v8 = 8'($urandom);
            step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 6) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                 v8,
                 ($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0);
        end

        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
